// File: rtl/ct_spsram_512x59_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ct_spsram_ctrl_pkg
// Shared types and defaults for the 512x59 single-port SRAM controller.
//   state_e        : FSM state encoding (BOOT/INIT/IDLE)
//   *_DEF          : default address/data width and depth
//   WEN_NONE       : all-ones bit write enable (no bit written)
// ---------------------------------------------------------------------------
package ct_spsram_ctrl_pkg;

   localparam int ADDR_WIDTH_DEF = 9;
   localparam int DATA_WIDTH_DEF = 59;
   localparam int DEPTH_DEF      = 512;

   localparam logic [DATA_WIDTH_DEF-1:0] WEN_NONE = '1;

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_INIT = 2'b01,
      ST_IDLE = 2'b10
   } state_e;

endpackage

// File: rtl/ct_spsram_512x59_ctrl_if.sv
// ---------------------------------------------------------------------------
// ct_spsram_512x59_ctrl_if
// Client request/response channel of the SRAM controller.
//   master : client side (drives requests, consumes responses)
//   slave  : controller side (accepts requests, returns read data, init_done)
// ---------------------------------------------------------------------------
interface ct_spsram_512x59_ctrl_if
   import ct_spsram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  req_vld;
   logic                  req_rdy;
   logic                  req_wr;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [DATA_WIDTH-1:0] req_bmask;
   logic                  rsp_vld;
   logic                  rsp_rdy;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  init_done;

   modport master (
      output req_vld, req_wr, req_addr, req_wdata, req_bmask, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_rdata, init_done
   );

   modport slave (
      input  req_vld, req_wr, req_addr, req_wdata, req_bmask, rsp_rdy,
      output req_rdy, rsp_vld, rsp_rdata, init_done
   );
endinterface

// File: rtl/ct_spsram_512x59_ctrl_init_seq.sv
// ---------------------------------------------------------------------------
// ct_spsram_init_seq
// Address counter for the post-reset zero-fill sweep. Only instantiated when
// CT_SPSRAM_CTRL_INIT_EN is defined.
//   clk, rst : clock, async active-high reset
//   en       : sweep active this cycle (counter advances)
//   addr     : current sweep address
//   last     : addr is the final word (DEPTH-1)
// ---------------------------------------------------------------------------
module ct_spsram_init_seq #(
   parameter int ADDR_WIDTH = 9,
   parameter int DEPTH      = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] cnt_d;

   assign last = (cnt_q == ADDR_WIDTH'(DEPTH - 1));
   assign addr = cnt_q;

   // Explicit wrap so a non power-of-two DEPTH still returns to 0.
   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/ct_spsram_512x59_ctrl.sv
// ---------------------------------------------------------------------------
// ct_spsram_512x59_ctrl
// Initiator-side controller for a 512x59 single-port SRAM (A/CEN/GWEN/WEN/D/Q,
// active-low enables, 1-cycle read latency, Q held while CEN is high).
// Optional zero-fill sweep after reset: CT_SPSRAM_CTRL_INIT_EN.
//   CLK, RST        : clock, async active-high reset
//   bus (slave)     : client req/rsp valid-ready channel + init_done
//   A/CEN/GWEN/WEN/D: SRAM drive, combinational from state and accept
//   Q               : SRAM read data, passed straight to rsp_rdata
//
// state   | meaning
// BOOT    | one idle cycle after reset, no access
// INIT    | zero-fill sweep, one write per cycle (macro builds only)
// IDLE    | serving client requests
// ---------------------------------------------------------------------------
module ct_spsram_512x59_ctrl
   import ct_spsram_ctrl_pkg::*;
#(
   parameter int                  ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int                  DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int                  DEPTH      = DEPTH_DEF,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
   input  logic                    CLK,
   input  logic                    RST,
   ct_spsram_512x59_ctrl_if.slave  bus,
   output logic [ADDR_WIDTH-1:0]   A,
   output logic                    CEN,
   output logic                    GWEN,
   output logic [DATA_WIDTH-1:0]   WEN,
   output logic [DATA_WIDTH-1:0]   D,
   input  logic [DATA_WIDTH-1:0]   Q
);
   state_e state_q, state_d;
   logic   rsp_vld_q, rsp_vld_d;
   logic   init_done_q, init_done_d;
   logic   accept;
   logic   stall;
   logic   [ADDR_WIDTH-1:0] init_addr;
   logic   init_last;

`ifdef CT_SPSRAM_CTRL_INIT_EN
   localparam state_e BOOT_NEXT = ST_INIT;

   ct_spsram_init_seq #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_init_seq (
      .clk  (CLK),
      .rst  (RST),
      .en   (state_q == ST_INIT),
      .addr (init_addr),
      .last (init_last)
   );
`else
   localparam state_e BOOT_NEXT = ST_IDLE;

   assign init_addr = '0;
   assign init_last = (init_addr == ADDR_WIDTH'(DEPTH - 1));
`endif

   // A pending, unconsumed response blocks new accesses so Q stays stable.
   assign stall       = rsp_vld_q && !bus.rsp_rdy;
   assign bus.req_rdy = (state_q == ST_IDLE) && !stall;
   assign accept      = bus.req_vld && bus.req_rdy;

   assign bus.rsp_vld   = rsp_vld_q;
   assign bus.rsp_rdata = Q;
   assign bus.init_done = init_done_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_BOOT;
         rsp_vld_q   <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_vld_q   <= rsp_vld_d;
         init_done_q <= init_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = BOOT_NEXT;
         ST_INIT: if (init_last) state_d = ST_IDLE;
         ST_IDLE: state_d = ST_IDLE;
         default: state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      rsp_vld_d   = rsp_vld_q;
      init_done_d = init_done_q | (state_d == ST_IDLE);
      if (accept && !bus.req_wr) rsp_vld_d = 1'b1;
      else if (bus.rsp_rdy)      rsp_vld_d = 1'b0;
   end

   always_comb begin
      A    = '0;
      CEN  = 1'b1;
      GWEN = 1'b1;
      WEN  = '1;
      D    = '0;
      case (state_q)
         ST_INIT: begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = init_addr;
            D    = INIT_VAL;
         end
         ST_IDLE: begin
            if (accept) begin
               CEN = 1'b0;
               A   = bus.req_addr;
               if (bus.req_wr) begin
                  GWEN = 1'b0;
                  WEN  = ~bus.req_bmask;
                  D    = bus.req_wdata;
               end
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_ct_spsram_512x59_ctrl.sv
module tb_ct_spsram_512x59_ctrl;
   localparam int AW = 9;
   localparam int DW = 59;

   logic          clk;
   logic          rst;
   logic [AW-1:0] a;
   logic          cen;
   logic          gwen;
   logic [DW-1:0] wen;
   logic [DW-1:0] d;
   logic [DW-1:0] q;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;

   logic [DW-1:0] ones;
   logic [DW-1:0] v0, v1, v2, vd;

   ct_spsram_512x59_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ct_spsram_512x59_ctrl dut (
      .CLK  (clk),
      .RST  (rst),
      .bus  (bus),
      .A    (a),
      .CEN  (cen),
      .GWEN (gwen),
      .WEN  (wen),
      .D    (d),
      .Q    (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural SRAM macro: 1-cycle read latency, Q held while CEN high
   logic [DW-1:0] mem [0:511];
   always @(posedge clk) begin
      if (!cen) begin
         if (!gwen) begin
            mem[a] <= (mem[a] & wen) | (d & ~wen);
            wr_count <= wr_count + 1;
         end else begin
            q <= mem[a];
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.req_vld   = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_bmask = '0;
      bus.rsp_rdy   = 1'b1;
   endtask

   task automatic drive_req(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] bmask);
      bus.req_vld   = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_bmask = bmask;
   endtask

   // leaves RST released at a negedge, state still BOOT
   task automatic do_reset();
      step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      step();
      rst = 1'b1;
      drive_req(1'b1, 9'h055, ones, ones);
      #1;
      checks++;
      if ({cen, gwen, wen, a, d} !== {1'b1, 1'b1, ones, 9'h0, 59'h0}) begin
         errors++;
         $display("FAIL reset_sram_idle: got cen=%0b gwen=%0b wen=%h a=%h d=%h exp cen=1 gwen=1 wen=all-ones a=0 d=0",
                  cen, gwen, wen, a, d);
      end
      checks++;
      if ({bus.rsp_vld, bus.init_done, bus.req_rdy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got rsp_vld=%0b init_done=%0b req_rdy=%0b exp 0 0 0",
                  bus.rsp_vld, bus.init_done, bus.req_rdy);
      end
      step();
      step();
      rst = 1'b0;
      #1;
      checks++;
      if ({cen, bus.req_rdy, bus.init_done} !== 3'b100) begin
         errors++;
         $display("FAIL boot_cycle: got cen=%0b req_rdy=%0b init_done=%0b exp 1 0 0",
                  cen, bus.req_rdy, bus.init_done);
      end
   endtask

`ifdef CT_SPSRAM_CTRL_INIT_EN
   task automatic test_init_sweep();
      for (int k = 0; k < 512; k++) begin
         step();
         #1;
         checks++;
         if ({cen, gwen, wen, a, d, bus.req_rdy, bus.init_done} !==
             {1'b0, 1'b0, 59'h0, 9'(k), 59'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL init_sweep_%0d: got cen=%0b gwen=%0b wen=%h a=%0d d=%h rdy=%0b done=%0b exp write of 0 at a=%0d rdy=0 done=0",
                     k, cen, gwen, wen, a, d, bus.req_rdy, bus.init_done, k);
         end
      end
      step();
      #1;
      checks++;
      if ({bus.init_done, bus.req_rdy, cen, gwen} !== 4'b1100) begin
         errors++;
         $display("FAIL init_done_rise: got done=%0b rdy=%0b cen=%0b gwen=%0b exp 1 1 0 0",
                  bus.init_done, bus.req_rdy, cen, gwen);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_sweep();
      do_reset();
      for (int k = 0; k <= 100; k++) step();
      #1;
      checks++;
      if ({cen, a} !== {1'b0, 9'd100}) begin
         errors++;
         $display("FAIL sweep_at_100: got cen=%0b a=%0d exp cen=0 a=100", cen, a);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({cen, gwen, wen, a, bus.rsp_vld} !== {1'b1, 1'b1, ones, 9'h0, 1'b0}) begin
         errors++;
         $display("FAIL sweep_reset_idle: got cen=%0b gwen=%0b wen=%h a=%0d rsp_vld=%0b exp 1 1 all-ones 0 0",
                  cen, gwen, wen, a, bus.rsp_vld);
      end
      step();
      rst = 1'b0;
      step();
      #1;
      checks++;
      if ({cen, gwen, a} !== {1'b0, 1'b0, 9'h0}) begin
         errors++;
         $display("FAIL sweep_restart: got cen=%0b gwen=%0b a=%0d exp 0 0 0", cen, gwen, a);
      end
      for (int k = 0; k < 512; k++) step();
      #1;
      checks++;
      if (bus.init_done !== 1'b1) begin
         errors++;
         $display("FAIL sweep_restart_done: got %0b exp 1", bus.init_done);
      end
   endtask
`else
   task automatic test_boot_noinit();
      checks++;
      if (wr_count !== 0) begin
         errors++;
         $display("FAIL no_early_writes: got %0d exp 0", wr_count);
      end
      step();
      #1;
      checks++;
      if ({bus.init_done, bus.req_rdy, cen, gwen, a} !== {1'b1, 1'b1, 1'b0, 1'b0, 9'h055}) begin
         errors++;
         $display("FAIL first_accept: got done=%0b rdy=%0b cen=%0b gwen=%0b a=%h exp 1 1 0 0 055",
                  bus.init_done, bus.req_rdy, cen, gwen, a);
      end
      step();
      idle_inputs();
      #1;
      checks++;
      if (wr_count !== 1) begin
         errors++;
         $display("FAIL first_write_count: got %0d exp 1", wr_count);
      end
   endtask
`endif

   task automatic test_write_read();
      step();
      drive_req(1'b1, 9'h1A5, 59'h123_4567_89AB_CDEF, ones);
      #1;
      checks++;
      if ({bus.req_rdy, cen, gwen, wen, a, d} !==
          {1'b1, 1'b0, 1'b0, 59'h0, 9'h1A5, 59'h123_4567_89AB_CDEF}) begin
         errors++;
         $display("FAIL wr_drive: got rdy=%0b cen=%0b gwen=%0b wen=%h a=%h d=%h exp 1 0 0 0 1a5 123456789abcdef",
                  bus.req_rdy, cen, gwen, wen, a, d);
      end
      step();
      drive_req(1'b0, 9'h1A5, ones, ones);
      #1;
      checks++;
      if ({bus.rsp_vld, cen, gwen, wen, a, d} !== {1'b0, 1'b0, 1'b1, ones, 9'h1A5, 59'h0}) begin
         errors++;
         $display("FAIL rd_drive: got rsp_vld=%0b cen=%0b gwen=%0b wen=%h a=%h d=%h exp 0 0 1 all-ones 1a5 0",
                  bus.rsp_vld, cen, gwen, wen, a, d);
      end
      step();
      idle_inputs();
      #1;
      checks++;
      if ({bus.rsp_vld, bus.rsp_rdata} !== {1'b1, 59'h123_4567_89AB_CDEF}) begin
         errors++;
         $display("FAIL rd_rsp: got vld=%0b data=%h exp 1 123456789abcdef", bus.rsp_vld, bus.rsp_rdata);
      end
      step();
      #1;
      checks++;
      if (bus.rsp_vld !== 1'b0) begin
         errors++;
         $display("FAIL rd_rsp_drop: got %0b exp 0", bus.rsp_vld);
      end
   endtask

   task automatic test_partial_write();
      step();
      drive_req(1'b1, 9'd3, 59'h0, ones);
      step();
      drive_req(1'b1, 9'd3, ones, 59'hFF);
      #1;
      checks++;
      if ({cen, gwen, wen} !== {1'b0, 1'b0, ~59'hFF}) begin
         errors++;
         $display("FAIL partial_wen: got cen=%0b gwen=%0b wen=%h exp 0 0 %h", cen, gwen, wen, ~59'hFF);
      end
      step();
      drive_req(1'b0, 9'd3, 59'h0, 59'h0);
      step();
      idle_inputs();
      #1;
      checks++;
      if ({bus.rsp_vld, bus.rsp_rdata} !== {1'b1, 59'h0FF}) begin
         errors++;
         $display("FAIL partial_rd: got vld=%0b data=%h exp 1 0ff", bus.rsp_vld, bus.rsp_rdata);
      end
   endtask

   task automatic test_stall();
      step();
      drive_req(1'b1, 9'd0, v0, ones);
      step();
      drive_req(1'b1, 9'd1, v1, ones);
      step();
      drive_req(1'b1, 9'd2, v2, ones);
      step();
      drive_req(1'b0, 9'd0, 59'h0, 59'h0);
      bus.rsp_rdy = 1'b0;
      step();
      drive_req(1'b0, 9'd1, 59'h0, 59'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if ({bus.rsp_vld, bus.req_rdy, cen, bus.rsp_rdata} !== {1'b1, 1'b0, 1'b1, v0}) begin
            errors++;
            $display("FAIL stall_%0d: got vld=%0b rdy=%0b cen=%0b data=%h exp 1 0 1 %h",
                     k, bus.rsp_vld, bus.req_rdy, cen, bus.rsp_rdata, v0);
         end
         step();
      end
      bus.rsp_rdy = 1'b1;
      #1;
      checks++;
      if ({bus.rsp_vld, bus.req_rdy, cen, a, bus.rsp_rdata} !== {1'b1, 1'b1, 1'b0, 9'd1, v0}) begin
         errors++;
         $display("FAIL stall_release: got vld=%0b rdy=%0b cen=%0b a=%0d data=%h exp 1 1 0 1 %h",
                  bus.rsp_vld, bus.req_rdy, cen, a, bus.rsp_rdata, v0);
      end
      step();
      drive_req(1'b0, 9'd2, 59'h0, 59'h0);
      #1;
      checks++;
      if ({bus.rsp_vld, bus.req_rdy, bus.rsp_rdata} !== {1'b1, 1'b1, v1}) begin
         errors++;
         $display("FAIL b2b_rd1: got vld=%0b rdy=%0b data=%h exp 1 1 %h",
                  bus.rsp_vld, bus.req_rdy, bus.rsp_rdata, v1);
      end
      step();
      idle_inputs();
      #1;
      checks++;
      if ({bus.rsp_vld, bus.rsp_rdata} !== {1'b1, v2}) begin
         errors++;
         $display("FAIL b2b_rd2: got vld=%0b data=%h exp 1 %h", bus.rsp_vld, bus.rsp_rdata, v2);
      end
      step();
      #1;
      checks++;
      if (bus.rsp_vld !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drop: got %0b exp 0", bus.rsp_vld);
      end
   endtask

   task automatic test_write_during_rsp();
      step();
      drive_req(1'b1, 9'd5, vd, ones);
      step();
      drive_req(1'b0, 9'd0, 59'h0, 59'h0);
      step();
      drive_req(1'b1, 9'd5, ones, 59'h0);
      #1;
      checks++;
      if ({bus.rsp_vld, bus.req_rdy, cen, gwen, wen, bus.rsp_rdata} !==
          {1'b1, 1'b1, 1'b0, 1'b0, ones, v0}) begin
         errors++;
         $display("FAIL wr_in_rsp: got vld=%0b rdy=%0b cen=%0b gwen=%0b wen=%h data=%h exp 1 1 0 0 all-ones %h",
                  bus.rsp_vld, bus.req_rdy, cen, gwen, wen, bus.rsp_rdata, v0);
      end
      step();
      drive_req(1'b0, 9'd5, 59'h0, 59'h0);
      #1;
      checks++;
      if (bus.rsp_vld !== 1'b0) begin
         errors++;
         $display("FAIL wr_in_rsp_drop: got %0b exp 0", bus.rsp_vld);
      end
      step();
      idle_inputs();
      #1;
      checks++;
      if ({bus.rsp_vld, bus.rsp_rdata} !== {1'b1, vd}) begin
         errors++;
         $display("FAIL zero_mask_keep: got vld=%0b data=%h exp 1 %h", bus.rsp_vld, bus.rsp_rdata, vd);
      end
   endtask

   task automatic test_reset_mid_read();
      step();
      drive_req(1'b0, 9'd1, 59'h0, 59'h0);
      step();
      idle_inputs();
      bus.rsp_rdy = 1'b0;
      #1;
      checks++;
      if (bus.rsp_vld !== 1'b1) begin
         errors++;
         $display("FAIL mid_rd_pending: got %0b exp 1", bus.rsp_vld);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.rsp_vld, bus.init_done, cen, gwen} !== 4'b0011) begin
         errors++;
         $display("FAIL mid_rd_reset: got vld=%0b done=%0b cen=%0b gwen=%0b exp 0 0 1 1",
                  bus.rsp_vld, bus.init_done, cen, gwen);
      end
      step();
      rst = 1'b0;
      bus.rsp_rdy = 1'b1;
      step();
      #1;
      checks++;
      if (bus.rsp_vld !== 1'b0) begin
         errors++;
         $display("FAIL mid_rd_after: got %0b exp 0", bus.rsp_vld);
      end
   endtask

   initial begin
      ones = '1;
      v0 = 59'h0AA;
      v1 = 59'h155_0000_0000;
      v2 = 59'h7_0000_0000_0001;
      vd = 59'h5A5A;
      rst = 1'b0;
      idle_inputs();
      test_reset();
`ifdef CT_SPSRAM_CTRL_INIT_EN
      test_init_sweep();
`else
      test_boot_noinit();
`endif
      test_write_read();
      test_partial_write();
      test_stall();
      test_write_during_rsp();
      test_reset_mid_read();
`ifdef CT_SPSRAM_CTRL_INIT_EN
      test_reset_mid_sweep();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
